encrypt_stream_sequencer: RTL and testbench
===========================================

Name: encrypt_stream_sequencer

Overview:
Sequential wrapper that drives the combinational `encrypt` datapath from byte streams.
- Collects `p_message_length` text bytes over a valid/ready input.
- Holds a loadable secret.
- Presents the assembled message and the secret to one `encrypt` instance, registers the cipher, and streams the cipher bytes out over valid/ready.
- Sits between a host byte interface (UART/bus bridge) and the cipher core.

Parameters:
- p_message_length, 9, characters per message (bytes collected per encryption)
- p_secret_length, 6, characters in the secret key
- p_count_width, 16, width of the completed-message counter

Ports:
- i_w_clk  input  1  clock; all state updates on the rising edge
- i_w_rst_n  input  1  asynchronous active-low reset
- i_w_secret  input  p_secret_length*8  secret; character 0 in the MSB byte
- i_w_secret_load  input  1  pulse: capture i_w_secret into the secret register
- i_w_text_byte  input  8  text character
- i_w_text_valid  input  1  text byte valid
- o_w_text_ready  output  1  sequencer accepts a text byte this cycle
- o_r_cipher_byte  output  8  cipher character
- o_r_cipher_valid  output  1  cipher byte valid (registered)
- i_w_cipher_ready  input  1  downstream accepts a cipher byte
- o_r_secret_valid  output  1  a secret has been loaded since reset
- o_r_busy  output  1  high in ENCRYPT and EMIT
- o_r_msg_count  output  p_count_width  messages fully emitted; wraps at 2^p_count_width

Behaviour:
- Reset (asynchronous, i_w_rst_n=0):
  - State=IDLE.
  - Secret register, text buffer, cipher buffer and indices cleared to 0.
  - o_r_cipher_byte=0, o_r_cipher_valid=0, o_r_secret_valid=0, o_r_busy=0, o_r_msg_count=0.
  - Reset mid-message discards all partial data; no output bytes are emitted afterwards.
- Secret register:
  - i_w_secret_load=1 captures i_w_secret on that edge in any state and sets o_r_secret_valid=1.
  - The `encrypt` instance reads a shadow copy of the secret. The shadow is taken on the COLLECT->ENCRYPT transition, so a load during ENCRYPT/EMIT affects only the next message.
  - If the load coincides with the final text handshake, the new value is the one shadowed.
- Handshakes: a transfer occurs when valid&&ready on a rising edge. o_w_text_ready = (state==COLLECT), combinational from state only.
- States:
  - IDLE: o_w_text_ready=0. Go to COLLECT on the cycle after o_r_secret_valid becomes 1.
  - COLLECT:
    - Each text handshake stores the byte at index idx, with index 0 as the most significant byte of the message vector, then increments idx.
    - The handshake at idx=p_message_length-1 resets idx to 0 and moves to ENCRYPT.
    - Text bytes offered outside COLLECT are not consumed.
  - ENCRYPT (exactly 1 cycle):
    - The cipher buffer registers the `encrypt` output for the buffered text and the shadow secret.
    - o_r_cipher_byte loads cipher byte 0 (MSB byte) and o_r_cipher_valid is set; next state is EMIT.
  - EMIT:
    - o_r_cipher_valid stays 1 and o_r_cipher_byte stays stable until the handshake.
    - Each handshake advances to the next byte.
    - The handshake on byte p_message_length-1 clears o_r_cipher_valid, increments o_r_msg_count and returns to COLLECT.
    - The secret stays loaded, so IDLE is not re-entered.
- Latency:
  - First cipher byte is valid in the cycle after the ENCRYPT cycle, i.e. 2 edges after the last text handshake edge.
  - With i_w_cipher_ready held at 1, one cipher byte is emitted per cycle.
  - Minimum message period is p_message_length + 1 + p_message_length cycles.
- Backpressure: holding i_w_cipher_ready=0 freezes EMIT indefinitely with outputs stable. No bytes are lost or duplicated.
- Widths:
  - idx and the emit index are $clog2(p_message_length) bits wide.
  - The cipher for each character is the 8-bit output of `encrypt`; the sequencer passes it through unmodified.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, COLLECT=2'd1, ENCRYPT=2'd2, EMIT=2'd3
  - default widths: byte width 8, p_count_width
- One sub-module instance: the existing `encrypt` (parameters passed through).
- Text buffer, cipher buffer and secret shadow stay inside this module.

Test Plan:
1. Reset with no secret load; drive i_w_text_valid=1 for 20 cycles -> o_w_text_ready stays 0, o_r_cipher_valid stays 0, o_r_msg_count=0.
2. Load "DANILA", stream "tOpseCREt" back-to-back with i_w_cipher_ready=1 -> o_r_cipher_valid rises 2 edges after the last text handshake. Bytes emitted in order: 0x37, 0x2E, 0x30, 0x39, 0x24, 0x23, 0x35, 0x1B, 0x39. o_r_msg_count=1.
3. Repeat scenario 2 with i_w_cipher_ready toggling 1/0 every cycle and randomly stalled for 5 cycles -> the same 9 bytes, each held stable while stalled, no duplicates.
4. Assert i_w_secret_load with a different secret during EMIT of message 1 -> message 1 cipher unchanged; message 2 ("tOpseCREt" again) is encrypted with the new secret.
5. Assert i_w_rst_n=0 after 4 text bytes, release, reload "DANILA", stream the full message -> first output byte is 0x37 (the partial message is discarded).
6. Force o_r_msg_count near 2^p_count_width-1 (p_count_width=2 build): run 5 messages -> count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/encrypt_stream_sequencer_pkg.sv
// Shared definitions for the encrypt stream sequencer and its cipher core.
// Holds the FSM encoding, default widths and the per-position whitening table.
// No logic of its own; imported by every file in this slice.
package encrypt_stream_sequencer_pkg;

  localparam int BYTE_W  = 8;
  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ENCRYPT = 2'd2,
    ST_EMIT    = 2'd3
  } state_t;

  // Position-dependent whitening byte mixed into every cipher character,
  // so repeated text/key pairs at different offsets give different output.
  function automatic logic [7:0] whiten(input int pos);
    case (pos % 16)
      0:       return 8'h07;
      1:       return 8'h20;
      2:       return 8'h0E;
      3:       return 8'h03;
      4:       return 8'h0D;
      5:       return 8'h21;
      6:       return 8'h23;
      7:       return 8'h1F;
      8:       return 8'h03;
      9:       return 8'h5A;
      10:      return 8'h3C;
      11:      return 8'h11;
      12:      return 8'h6B;
      13:      return 8'h2D;
      14:      return 8'h49;
      default: return 8'h72;
    endcase
  endfunction

endpackage

// File: rtl/encrypt.sv
// Combinational cipher core: text char i ^ key char (i mod key length) ^ whitening(i).
// Latency: zero cycles, purely combinational.
// No flow control; the caller holds inputs stable while it samples the output.
module encrypt
  import encrypt_stream_sequencer_pkg::*;
#(
  parameter int p_message_length = 9,
  parameter int p_secret_length  = 6
) (
  input  logic [p_message_length*BYTE_W-1:0] i_w_text,
  input  logic [p_secret_length*BYTE_W-1:0]  i_w_secret,
  output logic [p_message_length*BYTE_W-1:0] o_w_cipher
);

  // Character 0 sits in the MSB byte of both text and secret vectors.
  always_comb begin
    o_w_cipher = '0;
    for (int i = 0; i < p_message_length; i++) begin
      o_w_cipher[(p_message_length-1-i)*BYTE_W +: BYTE_W] =
          i_w_text[(p_message_length-1-i)*BYTE_W +: BYTE_W]
        ^ i_w_secret[(p_secret_length-1-(i % p_secret_length))*BYTE_W +: BYTE_W]
        ^ whiten(i);
    end
  end

endmodule

// File: rtl/encrypt_stream_sequencer.sv
// Collects a message of text bytes, encrypts it against a shadowed secret, streams cipher bytes out.
// Latency: first cipher byte valid 2 edges after the last text handshake, then one byte per cycle.
// Text input is refused outside COLLECT; cipher output holds byte and valid while ready is low.
module encrypt_stream_sequencer
  import encrypt_stream_sequencer_pkg::*;
#(
  parameter int p_message_length = 9,
  parameter int p_secret_length  = 6,
  parameter int p_count_width    = COUNT_W
) (
  input  logic                              i_w_clk,
  input  logic                              i_w_rst_n,
  input  logic [p_secret_length*BYTE_W-1:0] i_w_secret,
  input  logic                              i_w_secret_load,
  input  logic [BYTE_W-1:0]                 i_w_text_byte,
  input  logic                              i_w_text_valid,
  output logic                              o_w_text_ready,
  output logic [BYTE_W-1:0]                 o_r_cipher_byte,
  output logic                              o_r_cipher_valid,
  input  logic                              i_w_cipher_ready,
  output logic                              o_r_secret_valid,
  output logic                              o_r_busy,
  output logic [p_count_width-1:0]          o_r_msg_count
);

  localparam int IDX_W = (p_message_length > 1) ? $clog2(p_message_length) : 1;
  localparam int MSG_W = p_message_length * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(p_message_length - 1);

  state_t                            state_q, state_d;
  logic [p_secret_length*BYTE_W-1:0] secret_q, shadow_q;
  logic [MSG_W-1:0]                  text_q, text_d, cipher_q, cipher_w;
  logic [IDX_W-1:0]                  idx_q, emit_q, emit_nxt;
  logic [BYTE_W-1:0]                 next_byte;
  logic                              text_hs, cipher_hs, last_text, last_emit;

  assign o_w_text_ready = (state_q == ST_COLLECT);
  assign text_hs        = i_w_text_valid && o_w_text_ready;
  assign cipher_hs      = o_r_cipher_valid && i_w_cipher_ready && (state_q == ST_EMIT);
  assign last_text      = text_hs && (idx_q == LAST_IDX);
  assign last_emit      = cipher_hs && (emit_q == LAST_IDX);
  assign emit_nxt       = emit_q + 1'b1;

  encrypt #(
    .p_message_length (p_message_length),
    .p_secret_length  (p_secret_length)
  ) u_encrypt (
    .i_w_text   (text_q),
    .i_w_secret (shadow_q),
    .o_w_cipher (cipher_w)
  );

  // Next-state: IDLE only until the first secret arrives, then COLLECT/ENCRYPT/EMIT loop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (o_r_secret_valid) state_d = ST_COLLECT;
      ST_COLLECT: if (last_text)        state_d = ST_ENCRYPT;
      ST_ENCRYPT:                       state_d = ST_EMIT;
      ST_EMIT:    if (last_emit)        state_d = ST_COLLECT;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Byte steering: where the incoming text byte lands, and which cipher byte goes out next.
  always_comb begin
    text_d    = text_q;
    next_byte = '0;
    for (int i = 0; i < p_message_length; i++) begin
      if (idx_q == IDX_W'(i))
        text_d[(p_message_length-1-i)*BYTE_W +: BYTE_W] = i_w_text_byte;
      if (emit_nxt == IDX_W'(i))
        next_byte = cipher_q[(p_message_length-1-i)*BYTE_W +: BYTE_W];
    end
  end

  // State register.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Secret register plus the shadow the core sees; a load on the final text edge wins.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      secret_q         <= '0;
      shadow_q         <= '0;
      o_r_secret_valid <= 1'b0;
    end else begin
      if (i_w_secret_load) begin
        secret_q         <= i_w_secret;
        o_r_secret_valid <= 1'b1;
      end
      if (last_text)
        shadow_q <= i_w_secret_load ? i_w_secret : secret_q;
    end
  end

  // Text collection: store byte at idx, wrap idx after the last character.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      text_q <= '0;
      idx_q  <= '0;
    end else if (text_hs) begin
      text_q <= text_d;
      idx_q  <= last_text ? '0 : idx_q + 1'b1;
    end
  end

  // Cipher capture in ENCRYPT and byte-by-byte emission in EMIT.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      cipher_q         <= '0;
      emit_q           <= '0;
      o_r_cipher_byte  <= '0;
      o_r_cipher_valid <= 1'b0;
      o_r_busy         <= 1'b0;
      o_r_msg_count    <= '0;
    end else begin
      o_r_busy <= (state_d == ST_ENCRYPT) || (state_d == ST_EMIT);
      if (state_q == ST_ENCRYPT) begin
        cipher_q         <= cipher_w;
        o_r_cipher_byte  <= cipher_w[MSG_W-1 -: BYTE_W];
        o_r_cipher_valid <= 1'b1;
        emit_q           <= '0;
      end else if (cipher_hs) begin
        if (emit_q == LAST_IDX) begin
          o_r_cipher_valid <= 1'b0;
          emit_q           <= '0;
          o_r_msg_count    <= o_r_msg_count + 1'b1;
        end else begin
          emit_q          <= emit_nxt;
          o_r_cipher_byte <= next_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_encrypt_stream_sequencer.sv
module tb_encrypt_stream_sequencer;

  localparam int L = 9;
  localparam int S = 6;
  typedef logic [7:0] msg_t [L];
  typedef logic [7:0] key_t [S];

  localparam logic [7:0] WHITEN [16] = '{8'h07, 8'h20, 8'h0E, 8'h03, 8'h0D, 8'h21, 8'h23, 8'h1F,
                                         8'h03, 8'h5A, 8'h3C, 8'h11, 8'h6B, 8'h2D, 8'h49, 8'h72};
  localparam msg_t TOPSECRET = '{8'h74, 8'h4F, 8'h70, 8'h73, 8'h65, 8'h43, 8'h52, 8'h45, 8'h74};
  localparam key_t DANILA    = '{8'h44, 8'h41, 8'h4E, 8'h49, 8'h4C, 8'h41};
  localparam msg_t SPEC_EXP  = '{8'h37, 8'h2E, 8'h30, 8'h39, 8'h24, 8'h23, 8'h35, 8'h1B, 8'h39};

  logic           clk;
  logic           rst_n;
  logic [S*8-1:0] secret;
  logic           secret_load;
  logic [7:0]     text_byte;
  logic           text_valid;
  logic           text_ready, text_ready2;
  logic [7:0]     cipher_byte, cipher_byte2;
  logic           cipher_valid, cipher_valid2;
  logic           cipher_ready;
  logic           secret_valid, secret_valid2;
  logic           busy, busy2;
  logic [15:0]    msg_count;
  logic [1:0]     msg_count2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_count = 0;
  int stab_err = 0;
  int overlap_err = 0;
  int twin_err = 0;
  int rise_cyc = 0;
  int last_text_cyc = 0;
  int rdy_mode = 0;
  int stall_left = 0;
  logic prev_stall = 1'b0;
  logic prev_valid = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] out_q [$];
  int hs_cyc_q [$];

  encrypt_stream_sequencer u_dut (
    .i_w_clk          (clk),
    .i_w_rst_n        (rst_n),
    .i_w_secret       (secret),
    .i_w_secret_load  (secret_load),
    .i_w_text_byte    (text_byte),
    .i_w_text_valid   (text_valid),
    .o_w_text_ready   (text_ready),
    .o_r_cipher_byte  (cipher_byte),
    .o_r_cipher_valid (cipher_valid),
    .i_w_cipher_ready (cipher_ready),
    .o_r_secret_valid (secret_valid),
    .o_r_busy         (busy),
    .o_r_msg_count    (msg_count)
  );

  encrypt_stream_sequencer #(.p_count_width(2)) u_dut_w2 (
    .i_w_clk          (clk),
    .i_w_rst_n        (rst_n),
    .i_w_secret       (secret),
    .i_w_secret_load  (secret_load),
    .i_w_text_byte    (text_byte),
    .i_w_text_valid   (text_valid),
    .o_w_text_ready   (text_ready2),
    .o_r_cipher_byte  (cipher_byte2),
    .o_r_cipher_valid (cipher_valid2),
    .i_w_cipher_ready (cipher_ready),
    .o_r_secret_valid (secret_valid2),
    .o_r_busy         (busy2),
    .o_r_msg_count    (msg_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference cipher: char i of text, key char i mod S, whitening byte i mod 16.
  function automatic msg_t model_cipher(input msg_t t, input key_t k);
    msg_t r;
    for (int i = 0; i < L; i++) r[i] = t[i] ^ k[i % S] ^ WHITEN[i % 16];
    return r;
  endfunction

  function automatic logic [S*8-1:0] pack_key(input key_t k);
    logic [S*8-1:0] p;
    p = '0;
    for (int i = 0; i < S; i++) p[(S-1-i)*8 +: 8] = k[i];
    return p;
  endfunction

  function automatic msg_t rand_msg();
    msg_t m;
    for (int i = 0; i < L; i++) m[i] = 8'($urandom_range(32, 126));
    return m;
  endfunction

  function automatic key_t rand_key();
    key_t k;
    for (int i = 0; i < S; i++) k[i] = 8'($urandom_range(65, 90));
    if (k[0] == DANILA[0]) k[0] = 8'h5A;
    return k;
  endfunction

  // Observer: records accepted cipher bytes and watches stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall && (!cipher_valid || cipher_byte !== prev_byte)) stab_err++;
      if (cipher_valid && text_ready) overlap_err++;
      if (cipher_valid2 !== cipher_valid || cipher_byte2 !== cipher_byte || busy2 !== busy ||
          secret_valid2 !== secret_valid || text_ready2 !== text_ready) twin_err++;
      if (cipher_valid && !prev_valid) rise_cyc = cyc;
      if (text_valid && text_ready) last_text_cyc = cyc;
      if (cipher_valid && cipher_ready) begin
        out_q.push_back(cipher_byte);
        hs_cyc_q.push_back(cyc);
      end
      prev_stall = cipher_valid && !cipher_ready;
      prev_byte  = cipher_byte;
      prev_valid = cipher_valid;
    end
  end

  // Downstream ready pattern: 0 always, 1 toggle, 2 toggle plus 5-cycle stalls, 3 random.
  initial begin
    cipher_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: cipher_ready = 1'b1;
        1: cipher_ready = ~cipher_ready;
        2: begin
          if (stall_left > 0) begin
            cipher_ready = 1'b0;
            stall_left--;
          end else if (cipher_valid && $urandom_range(0, 4) == 0) begin
            cipher_ready = 1'b0;
            stall_left = 4;
          end else begin
            cipher_ready = ~cipher_ready;
          end
        end
        default: cipher_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic load_secret(input key_t k);
    secret = pack_key(k);
    secret_load = 1'b1;
    @(posedge clk);
    #1;
    secret_load = 1'b0;
  endtask

  // Offers nbytes of m; optionally pulses a secret load together with the final byte.
  task automatic send_text(input msg_t m, input int nbytes, input bit load_last, input key_t k2);
    int n;
    for (int i = 0; i < nbytes; i++) begin
      text_byte = m[i];
      text_valid = 1'b1;
      if (load_last && i == nbytes - 1) begin
        secret = pack_key(k2);
        secret_load = 1'b1;
      end
      n = 0;
      @(negedge clk);
      while (!text_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (n >= 300) begin
        bad++;
        $display("FAIL text_accept byte%0d: ready=%0b after %0d cycles, required 1", i, text_ready, n);
      end
      @(posedge clk);
      #1;
      secret_load = 1'b0;
    end
    text_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int c;
    c = 0;
    while (out_q.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (out_q.size() < n) begin
      bad++;
      $display("FAIL %s timeout: got %0d bytes, required %0d", tag, out_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    secret = '0;
    secret_load = 1'b0;
    text_byte = 8'h00;
    text_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({text_ready, cipher_valid, secret_valid, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: ready/cvalid/svalid/busy=%b, required 0000",
               {text_ready, cipher_valid, secret_valid, busy});
    end
    total++;
    if (cipher_byte !== 8'h00) begin
      bad++;
      $display("FAIL reset_byte: got %h, required 00", cipher_byte);
    end
    total++;
    if (msg_count !== 16'd0 || msg_count2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d/%0d, required 0/0", msg_count, msg_count2);
    end
    @(posedge clk);
    #1;
    text_valid = 1'b1;
    text_byte = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (text_ready !== 1'b0 || cipher_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_no_accept cycle%0d: ready=%b cvalid=%b, required 0 0", i, text_ready, cipher_valid);
      end
    end
    total++;
    if (msg_count !== 16'd0) begin
      bad++;
      $display("FAIL idle_count: got %0d, required 0", msg_count);
    end
    @(posedge clk);
    #1;
    text_valid = 1'b0;
  endtask

  task automatic test_basic();
    rdy_mode = 0;
    out_q.delete();
    hs_cyc_q.delete();
    load_secret(DANILA);
    send_text(TOPSECRET, L, 1'b0, DANILA);
    wait_bytes(L, "basic");
    if (out_q.size() >= L) begin
      for (int i = 0; i < L; i++) begin
        total++;
        if (out_q[i] !== SPEC_EXP[i]) begin
          bad++;
          $display("FAIL basic byte%0d: got %h, required %h", i, out_q[i], SPEC_EXP[i]);
        end
      end
      total++;
      if (hs_cyc_q[L-1] - hs_cyc_q[0] != L - 1) begin
        bad++;
        $display("FAIL basic_rate: %0d cycles for %0d bytes, required %0d", hs_cyc_q[L-1] - hs_cyc_q[0], L, L - 1);
      end
    end
    total++;
    if (rise_cyc - last_text_cyc != 2) begin
      bad++;
      $display("FAIL basic_latency: valid rose %0d edges after last text, required 2", rise_cyc - last_text_cyc);
    end
    exp_count++;
    total++;
    if (msg_count !== 16'(exp_count) || msg_count2 !== 2'(exp_count)) begin
      bad++;
      $display("FAIL basic_count: got %0d/%0d, required %0d", msg_count, msg_count2, exp_count);
    end
    total++;
    if (busy !== 1'b0 || text_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_return: busy=%b ready=%b, required 0 1", busy, text_ready);
    end
    out_q.delete();
  endtask

  task automatic test_backpressure();
    int s0;
    s0 = stab_err;
    rdy_mode = 2;
    send_text(TOPSECRET, L, 1'b0, DANILA);
    wait_bytes(L, "bp");
    repeat (6) @(negedge clk);
    total++;
    if (out_q.size() != L) begin
      bad++;
      $display("FAIL bp_count_bytes: got %0d bytes, required %0d", out_q.size(), L);
    end
    if (out_q.size() >= L) begin
      for (int i = 0; i < L; i++) begin
        total++;
        if (out_q[i] !== SPEC_EXP[i]) begin
          bad++;
          $display("FAIL bp byte%0d: got %h, required %h", i, out_q[i], SPEC_EXP[i]);
        end
      end
    end
    total++;
    if (stab_err != s0) begin
      bad++;
      $display("FAIL bp_stable: %0d unstable stall cycles, required 0", stab_err - s0);
    end
    exp_count++;
    total++;
    if (msg_count !== 16'(exp_count)) begin
      bad++;
      $display("FAIL bp_msg_count: got %0d, required %0d", msg_count, exp_count);
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
    out_q.delete();
  endtask

  task automatic test_secret_swap();
    key_t k2;
    msg_t e1, e2;
    int c;
    k2 = rand_key();
    e1 = model_cipher(TOPSECRET, DANILA);
    e2 = model_cipher(TOPSECRET, k2);
    rdy_mode = 0;
    send_text(TOPSECRET, L, 1'b0, DANILA);
    c = 0;
    @(negedge clk);
    while (!cipher_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    load_secret(k2);
    wait_bytes(L, "swap1");
    if (out_q.size() >= L) begin
      for (int i = 0; i < L; i++) begin
        total++;
        if (out_q[i] !== e1[i]) begin
          bad++;
          $display("FAIL swap_old byte%0d: got %h, required %h", i, out_q[i], e1[i]);
        end
      end
    end
    out_q.delete();
    exp_count++;
    send_text(TOPSECRET, L, 1'b0, DANILA);
    wait_bytes(L, "swap2");
    if (out_q.size() >= L) begin
      for (int i = 0; i < L; i++) begin
        total++;
        if (out_q[i] !== e2[i]) begin
          bad++;
          $display("FAIL swap_new byte%0d: got %h, required %h", i, out_q[i], e2[i]);
        end
      end
    end
    out_q.delete();
    exp_count++;
    total++;
    if (msg_count !== 16'(exp_count) || secret_valid !== 1'b1) begin
      bad++;
      $display("FAIL swap_count: count=%0d svalid=%b, required %0d 1", msg_count, secret_valid, exp_count);
    end
  endtask

  task automatic test_coincident_load();
    key_t k3;
    msg_t m, e;
    k3 = rand_key();
    m = rand_msg();
    e = model_cipher(m, k3);
    send_text(m, L, 1'b1, k3);
    wait_bytes(L, "coincide");
    if (out_q.size() >= L) begin
      for (int i = 0; i < L; i++) begin
        total++;
        if (out_q[i] !== e[i]) begin
          bad++;
          $display("FAIL coincide byte%0d: got %h, required %h", i, out_q[i], e[i]);
        end
      end
    end
    out_q.delete();
    exp_count++;
    load_secret(DANILA);
  endtask

  task automatic test_random();
    key_t k;
    msg_t m, e;
    int s0;
    s0 = stab_err;
    k = DANILA;
    for (int r = 0; r < 4; r++) begin
      rdy_mode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        k = rand_key();
        load_secret(k);
      end
      m = rand_msg();
      e = model_cipher(m, k);
      send_text(m, L, 1'b0, k);
      wait_bytes(L, "random");
      if (out_q.size() >= L) begin
        for (int i = 0; i < L; i++) begin
          total++;
          if (out_q[i] !== e[i]) begin
            bad++;
            $display("FAIL random%0d byte%0d: got %h, required %h", r, i, out_q[i], e[i]);
          end
        end
      end
      out_q.delete();
      exp_count++;
    end
    rdy_mode = 0;
    total++;
    if (stab_err != s0 || msg_count !== 16'(exp_count)) begin
      bad++;
      $display("FAIL random_summary: unstable=%0d count=%0d, required 0 %0d", stab_err - s0, msg_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    out_q.delete();
    send_text(TOPSECRET, 4, 1'b0, DANILA);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({text_ready, cipher_valid, secret_valid, busy} !== 4'b0000 || msg_count !== 16'd0) begin
      bad++;
      $display("FAIL midreset_async: flags=%b count=%0d, required 0000 0",
               {text_ready, cipher_valid, secret_valid, busy}, msg_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0;
    repeat (25) @(negedge clk);
    total++;
    if (out_q.size() != 0 || text_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet: %0d bytes ready=%b, required 0 bytes ready=0", out_q.size(), text_ready);
    end
    @(posedge clk);
    #1;
    load_secret(DANILA);
    send_text(TOPSECRET, L, 1'b0, DANILA);
    wait_bytes(L, "midreset");
    if (out_q.size() >= L) begin
      for (int i = 0; i < L; i++) begin
        total++;
        if (out_q[i] !== SPEC_EXP[i]) begin
          bad++;
          $display("FAIL midreset byte%0d: got %h, required %h", i, out_q[i], SPEC_EXP[i]);
        end
      end
    end
    out_q.delete();
    exp_count++;
    total++;
    if (msg_count !== 16'(exp_count)) begin
      bad++;
      $display("FAIL midreset_count: got %0d, required %0d", msg_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    msg_t m, e;
    int wrap_exp [5] = '{1, 2, 3, 0, 1};
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0;
    out_q.delete();
    load_secret(DANILA);
    for (int r = 0; r < 5; r++) begin
      m = rand_msg();
      e = model_cipher(m, DANILA);
      send_text(m, L, 1'b0, DANILA);
      wait_bytes(L, "wrap");
      if (out_q.size() >= L) begin
        for (int i = 0; i < L; i++) begin
          total++;
          if (out_q[i] !== e[i]) begin
            bad++;
            $display("FAIL wrap%0d byte%0d: got %h, required %h", r, i, out_q[i], e[i]);
          end
        end
      end
      out_q.delete();
      exp_count++;
      total++;
      if (msg_count2 !== 2'(wrap_exp[r]) || msg_count !== 16'(exp_count)) begin
        bad++;
        $display("FAIL wrap_count%0d: narrow=%0d wide=%0d, required %0d %0d",
                 r, msg_count2, msg_count, wrap_exp[r], exp_count);
      end
    end
    total++;
    if (twin_err != 0 || overlap_err != 0) begin
      bad++;
      $display("FAIL twin_overlap: twin=%0d overlap=%0d, required 0 0", twin_err, overlap_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_secret_swap();
    test_coincident_load();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
